// File: rtl/ysyx_23060096_rf_pkg.sv
// Shared types and default sizes for the register-file writeback arbiter.
package ysyx_23060096_rf_pkg;

  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DATA_WIDTH = 32;
  localparam int NUM_REGS      = 1 << RF_ADDR_WIDTH;

  typedef enum logic {
    REQ_EXU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

endpackage

// File: rtl/ysyx_23060096_rf_wb_arbiter_if.sv
// Writeback, issue and register-file write bundle between the pipeline and the arbiter.
interface ysyx_23060096_rf_wb_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);

  logic                       exu_valid;
  logic                       exu_ready;
  logic [ADDR_WIDTH-1:0]      exu_waddr;
  logic [DATA_WIDTH-1:0]      exu_wdata;

  logic                       lsu_valid;
  logic                       lsu_ready;
  logic [ADDR_WIDTH-1:0]      lsu_waddr;
  logic [DATA_WIDTH-1:0]      lsu_wdata;

  logic                       iss_valid;
  logic [ADDR_WIDTH-1:0]      iss_rd;
  logic [ADDR_WIDTH-1:0]      iss_rs1;
  logic [ADDR_WIDTH-1:0]      iss_rs2;
  logic                       iss_stall;

  logic                       rf_wen;
  logic [ADDR_WIDTH-1:0]      rf_waddr;
  logic [DATA_WIDTH-1:0]      rf_wdata;
  logic [(2**ADDR_WIDTH)-1:0] busy_vec;

  modport slave (
    input  exu_valid, exu_waddr, exu_wdata,
    input  lsu_valid, lsu_waddr, lsu_wdata,
    input  iss_valid, iss_rd, iss_rs1, iss_rs2,
    output exu_ready, lsu_ready, iss_stall,
    output rf_wen, rf_waddr, rf_wdata, busy_vec
  );

  modport master (
    output exu_valid, exu_waddr, exu_wdata,
    output lsu_valid, lsu_waddr, lsu_wdata,
    output iss_valid, iss_rd, iss_rs1, iss_rs2,
    input  exu_ready, lsu_ready, iss_stall,
    input  rf_wen, rf_waddr, rf_wdata, busy_vec
  );

endinterface

// File: rtl/ysyx_23060096_rr_arb2.sv
// Two-requester round-robin arbiter (EXU vs LSU) with combinational ready.
module ysyx_23060096_rr_arb2
  import ysyx_23060096_rf_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic exu_valid,
  input  logic lsu_valid,
  output logic exu_ready,
  output logic lsu_ready
);

  req_id_e rr_q;

  always_comb begin
    exu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (rstn) begin
      if (exu_valid && lsu_valid) begin
        exu_ready = (rr_q == REQ_EXU);
        lsu_ready = (rr_q == REQ_LSU);
      end else begin
        exu_ready = exu_valid;
        lsu_ready = lsu_valid;
      end
    end
  end

  // pointer moves to the requester that did not just fire
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_q <= REQ_EXU;
    end else if (exu_valid && exu_ready) begin
      rr_q <= REQ_LSU;
    end else if (lsu_valid && lsu_ready) begin
      rr_q <= REQ_EXU;
    end
  end

endmodule

// File: rtl/ysyx_23060096_rf_wb_arbiter.sv
// Register-file writeback arbiter with busy-register scoreboard for issue hazards.
// Optional macro YSYX_23060096_RF_ARB_BYPASS_EN lets same-cycle writeback clear an issue hazard.
module ysyx_23060096_rf_wb_arbiter
  import ysyx_23060096_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rstn,
  ysyx_23060096_rf_wb_arbiter_if.slave  wb
);

  localparam int NREGS = (ADDR_WIDTH == RF_ADDR_WIDTH) ? NUM_REGS : (1 << ADDR_WIDTH);

  logic                  exu_fire_p0;
  logic                  lsu_fire_p0;
  logic                  fire_p0;
  logic [ADDR_WIDTH-1:0] waddr_p0;
  logic [DATA_WIDTH-1:0] wdata_p0;

  logic [NREGS-1:0]      busy_q;
  logic [NREGS-1:0]      clr_vec;
  logic [NREGS-1:0]      set_vec;
  logic [NREGS-1:0]      chk_vec;
  logic [NREGS-1:0]      busy_d;
  logic                  stall;

  logic                  wen_p1;
  logic [ADDR_WIDTH-1:0] waddr_p1;
  logic [DATA_WIDTH-1:0] wdata_p1;

  ysyx_23060096_rr_arb2 u_arb (
    .clk       (clk),
    .rstn      (rstn),
    .exu_valid (wb.exu_valid),
    .lsu_valid (wb.lsu_valid),
    .exu_ready (wb.exu_ready),
    .lsu_ready (wb.lsu_ready)
  );

  // ---- p0: grant select and scoreboard update ----
  always_comb begin
    exu_fire_p0 = wb.exu_valid && wb.exu_ready;
    lsu_fire_p0 = wb.lsu_valid && wb.lsu_ready;
    fire_p0     = exu_fire_p0 || lsu_fire_p0;
    waddr_p0    = lsu_fire_p0 ? wb.lsu_waddr : wb.exu_waddr;
    wdata_p0    = lsu_fire_p0 ? wb.lsu_wdata : wb.exu_wdata;
  end

  always_comb begin
    clr_vec = '0;
    if (fire_p0) begin
      clr_vec[waddr_p0] = 1'b1;
    end
`ifdef YSYX_23060096_RF_ARB_BYPASS_EN
    chk_vec = busy_q & ~clr_vec;
`else
    chk_vec = busy_q;
`endif
    stall = rstn && wb.iss_valid &&
            (chk_vec[wb.iss_rs1] || chk_vec[wb.iss_rs2] || chk_vec[wb.iss_rd]);
    set_vec = '0;
    if (rstn && wb.iss_valid && !stall && (wb.iss_rd != '0)) begin
      set_vec[wb.iss_rd] = 1'b1;
    end
    // set is OR-ed in after the clear so a same-cycle issue keeps the register busy
    busy_d    = (busy_q & ~clr_vec) | set_vec;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // ---- p1: registered register-file write port ----
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wen_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
    end else begin
      wen_p1 <= fire_p0 && (waddr_p0 != '0);
      if (fire_p0) begin
        waddr_p1 <= waddr_p0;
        wdata_p1 <= wdata_p0;
      end
    end
  end

  assign wb.iss_stall = stall;
  assign wb.rf_wen    = wen_p1;
  assign wb.rf_waddr  = waddr_p1;
  assign wb.rf_wdata  = wdata_p1;
  assign wb.busy_vec  = busy_q;

endmodule

// File: tb/tb_ysyx_23060096_rf_wb_arbiter.sv
// Scoreboard bench for the register-file writeback arbiter.
module tb_ysyx_23060096_rf_wb_arbiter;

`ifdef YSYX_23060096_RF_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } exp_t;

  logic clk;
  logic rstn;

  ysyx_23060096_rf_wb_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) wb ();

  ysyx_23060096_rf_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .wb   (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks;
  int    n_fail;
  exp_t  sb[$];
  logic [31:0] m_busy;
  logic        m_rr;
  logic [4:0]  m_la;
  logic [31:0] m_ld;
  int          grant;
  logic        obs_stall;
  int          g[4];
  int          exp_g[4] = '{0, 1, 0, 1};
  logic [31:0] saved_busy;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    exp_t        e;
    logic        fe, fl, st;
    logic [4:0]  a;
    logic [31:0] d, clr, chkv, setv;
    #3;
    obs_stall = wb.iss_stall;
    if (!rstn) begin
      chk("rst_exu_ready", wb.exu_ready, 0);
      chk("rst_lsu_ready", wb.lsu_ready, 0);
      chk("rst_iss_stall", wb.iss_stall, 0);
      m_busy = '0; m_rr = 1'b0; m_la = '0; m_ld = '0;
      e = '{wen: 1'b0, waddr: 5'd0, wdata: 32'd0};
      sb.push_back(e);
      grant = 2;
    end else begin
      fe = wb.exu_valid && (!wb.lsu_valid || m_rr == 1'b0);
      fl = wb.lsu_valid && (!wb.exu_valid || m_rr == 1'b1);
      chk("exu_ready", wb.exu_ready, fe);
      chk("lsu_ready", wb.lsu_ready, fl);
      a    = fl ? wb.lsu_waddr : wb.exu_waddr;
      d    = fl ? wb.lsu_wdata : wb.exu_wdata;
      clr  = (fe || fl) ? (32'd1 << a) : 32'd0;
      chkv = BYP ? (m_busy & ~clr) : m_busy;
      st   = wb.iss_valid && (chkv[wb.iss_rs1] || chkv[wb.iss_rs2] || chkv[wb.iss_rd]);
      chk("iss_stall", wb.iss_stall, st);
      setv = (wb.iss_valid && !st && wb.iss_rd != 5'd0) ? (32'd1 << wb.iss_rd) : 32'd0;
      if (fe || fl) begin
        m_la = a; m_ld = d;
        e = '{wen: (a != 5'd0), waddr: a, wdata: d};
      end else begin
        e = '{wen: 1'b0, waddr: m_la, wdata: m_ld};
      end
      sb.push_back(e);
      m_busy = ((m_busy & ~clr) | setv) & ~32'd1;
      if (fe) m_rr = 1'b1;
      else if (fl) m_rr = 1'b0;
      grant = fe ? 0 : (fl ? 1 : 2);
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("rf_wen",   wb.rf_wen,   e.wen);
    chk("rf_waddr", wb.rf_waddr, e.waddr);
    chk("rf_wdata", wb.rf_wdata, e.wdata);
    chk("busy_vec", wb.busy_vec, m_busy);
  endtask

  task automatic idle_inputs();
    wb.exu_valid = 0; wb.exu_waddr = 0; wb.exu_wdata = 0;
    wb.lsu_valid = 0; wb.lsu_waddr = 0; wb.lsu_wdata = 0;
    wb.iss_valid = 0; wb.iss_rd = 0; wb.iss_rs1 = 0; wb.iss_rs2 = 0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle_inputs();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    chk("reset_busy", wb.busy_vec, 0);
    chk("reset_wen",  wb.rf_wen,   0);

    // single EXU writeback
    wb.exu_valid = 1; wb.exu_waddr = 5'd5; wb.exu_wdata = 32'hDEADBEEF;
    tick();
    chk("exu_only_grant", grant, 0);
    chk("exu_only_wen",   wb.rf_wen, 1);
    chk("exu_only_waddr", wb.rf_waddr, 5);
    chk("exu_only_wdata", wb.rf_wdata, 32'hDEADBEEF);
    idle_inputs();
    tick();
    chk("hold_wen",   wb.rf_wen, 0);
    chk("hold_wdata", wb.rf_wdata, 32'hDEADBEEF);

    // alternation from reset
    do_reset();
    wb.exu_valid = 1; wb.exu_waddr = 5'd1; wb.exu_wdata = 32'h1111_0000;
    wb.lsu_valid = 1; wb.lsu_waddr = 5'd2; wb.lsu_wdata = 32'h2222_0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      g[i] = grant;
    end
    for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), g[i], exp_g[i]);
    idle_inputs();

    // RAW hazard on x7 released by an LSU writeback
    wb.iss_valid = 1; wb.iss_rd = 5'd7;
    tick();
    chk("busy7_set", wb.busy_vec[7], 1);
    wb.iss_rd = 5'd8; wb.iss_rs1 = 5'd7;
    tick();
    chk("raw_stall0", obs_stall, 1);
    tick();
    chk("raw_stall1", obs_stall, 1);
    wb.lsu_valid = 1; wb.lsu_waddr = 5'd7; wb.lsu_wdata = 32'h77;
    tick();
    chk("raw_stall_fire", obs_stall, !BYP);
    wb.lsu_valid = 0;
    if (!BYP) begin
      tick();
      chk("raw_stall_after", obs_stall, 0);
    end
    chk("busy8_set", wb.busy_vec[8], 1);
    idle_inputs();

    // write to x0
    saved_busy = wb.busy_vec;
    wb.exu_valid = 1; wb.exu_waddr = 5'd0; wb.exu_wdata = 32'h1234;
    tick();
    chk("x0_grant", grant, 0);
    chk("x0_wen",   wb.rf_wen, 0);
    chk("x0_busy",  wb.busy_vec, saved_busy);
    idle_inputs();

    // issue and writeback on the same register in one cycle
    wb.exu_valid = 1; wb.exu_waddr = 5'd3; wb.exu_wdata = 32'h33;
    wb.iss_valid = 1; wb.iss_rd = 5'd3;
    tick();
    chk("set_wins_idle", wb.busy_vec[3], 1);
    tick();
    chk("set_wins_busy", wb.busy_vec[3], BYP);
    idle_inputs();

    // reset in the middle of traffic
    do_reset();
    wb.iss_valid = 1; wb.iss_rd = 5'd7;
    tick();
    wb.iss_rd = 5'd3;
    tick();
    idle_inputs();
    chk("busy_88", wb.busy_vec, 32'h88);
    wb.exu_valid = 1; wb.exu_waddr = 5'd9;  wb.exu_wdata = 32'h99;
    wb.lsu_valid = 1; wb.lsu_waddr = 5'd10; wb.lsu_wdata = 32'hAA;
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("mid_rst_busy", wb.busy_vec, 0);
    chk("mid_rst_wen",  wb.rf_wen, 0);
    tick();
    chk("mid_rst_rr", grant, 0);
    idle_inputs();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rstn         = ($urandom_range(0, 59) != 0);
      wb.exu_valid = $urandom_range(0, 1);
      wb.exu_waddr = 5'($urandom_range(0, 15));
      wb.exu_wdata = $urandom;
      wb.lsu_valid = $urandom_range(0, 1);
      wb.lsu_waddr = 5'($urandom_range(0, 15));
      wb.lsu_wdata = $urandom;
      wb.iss_valid = $urandom_range(0, 1);
      wb.iss_rd    = 5'($urandom_range(0, 15));
      wb.iss_rs1   = 5'($urandom_range(0, 15));
      wb.iss_rs2   = 5'($urandom_range(0, 15));
      tick();
    end
    rstn = 1'b1;
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
